// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper phase sequencer.
package stepper_pkg;

  localparam int PH_W = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Phase index -> {A, AN, B, BN}; entry 7 is the leftmost nibble.
  localparam logic [7:0][3:0] COIL_MAP = 32'h9154_62A8;

  function automatic logic [3:0] coil_of(input logic [PH_W-1:0] phase);
    return COIL_MAP[phase];
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step-period prescaler: counts 0..P-1 while running and ticks on P-1.
module step_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic [DIV_W-1:0] period_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] period_eff;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    period_eff = (period_i == '0) ? DIV_W'(1) : period_i;
    tick_o     = run_i && (count_q == period_eff - DIV_W'(1));
    count_d    = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (run_i) begin
      count_d = tick_o ? '0 : count_q + DIV_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/stepper_seq_ctrl.sv
// Stepper-motor phase sequencer with step counts, rate prescaler and position tracking.
module stepper_seq_ctrl
  import stepper_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16,
  parameter int POS_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             DIR,
  input  logic             HALF,
  input  logic [DIV_W-1:0] PERIOD,
  input  logic             CMD_VALID,
  input  logic [CNT_W-1:0] CMD_STEPS,
  output logic             CMD_READY,
  output logic             BUSY,
  output logic             DONE,
  output logic [POS_W-1:0] POS,
  output logic             A,
  output logic             AN,
  output logic             B,
  output logic             BN
);

  logic [0:0]       state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic             dir_q, dir_d, half_q, half_d;
  logic             done_q, done_d;
  logic             en_seen_q;
  logic [3:0]       coil_q, coil_d;
  logic             accept, clear, tick;
  logic [1:0]       step_mag;

  assign CMD_READY = (state_q == ST_IDLE) && EN && en_seen_q;
  assign accept    = CMD_VALID && CMD_READY;
  assign BUSY      = (state_q == ST_RUN);
  assign DONE      = done_q;
  assign POS       = pos_q;
  assign {A, AN, B, BN} = coil_q;
  assign step_mag  = half_q ? 2'd1 : 2'd2;

  step_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk      (CLK),
    .rst_n    (RST),
    .clear_i  (clear),
    .run_i    (BUSY && EN),
    .period_i (period_q),
    .tick_o   (tick)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    pos_d    = pos_q;
    rem_d    = rem_q;
    period_d = period_q;
    dir_d    = dir_q;
    half_d   = half_q;
    done_d   = 1'b0;
    clear    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dir_d    = DIR;
          half_d   = HALF;
          period_d = PERIOD;
          if (CMD_STEPS == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d   = CMD_STEPS;
            clear   = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        // Abort wins over a step falling due on the same edge.
        if (!EN) begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end else if (tick) begin
          phase_d = dir_q ? phase_q - PH_W'(step_mag) : phase_q + PH_W'(step_mag);
          pos_d   = dir_q ? pos_q - POS_W'(step_mag) : pos_q + POS_W'(step_mag);
          rem_d   = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
    coil_d = EN ? coil_of(phase_d) : 4'b0000;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      pos_q     <= '0;
      rem_q     <= '0;
      period_q  <= '0;
      dir_q     <= 1'b0;
      half_q    <= 1'b0;
      done_q    <= 1'b0;
      en_seen_q <= 1'b0;
      coil_q    <= 4'b0000;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      pos_q     <= pos_d;
      rem_q     <= rem_d;
      period_q  <= period_d;
      dir_q     <= dir_d;
      half_q    <= half_d;
      done_q    <= done_d;
      en_seen_q <= en_seen_q | EN;
      coil_q    <= coil_d;
    end
  end

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// Scoreboard bench: stimulus pushes expected coil/DONE events, a monitor pops and compares them.
module tb_stepper_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        EN = 1'b0, DIR = 1'b0, HALF = 1'b0;
  logic [15:0] PERIOD = '0;
  logic        CMD_VALID = 1'b0;
  logic [15:0] CMD_STEPS = '0;
  logic        CMD_READY, BUSY, DONE, A, AN, B, BN;
  logic [31:0] POS;

  stepper_seq_ctrl #(.DIV_W(16), .CNT_W(16), .POS_W(32)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .DIR(DIR), .HALF(HALF), .PERIOD(PERIOD),
    .CMD_VALID(CMD_VALID), .CMD_STEPS(CMD_STEPS), .CMD_READY(CMD_READY),
    .BUSY(BUSY), .DONE(DONE), .POS(POS), .A(A), .AN(AN), .B(B), .BN(BN)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [3:0]  coils;
    logic        done;
    logic        busy;
    logic        ready;
    logic [31:0] pos;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  logic [3:0]  tb_map [8] = '{4'b1000, 4'b1010, 4'b0010, 4'b0110,
                              4'b0100, 4'b0101, 4'b0001, 4'b1001};
  int          m_phase = 0;
  logic [31:0] m_pos   = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic ev_t mk(input int c, input logic [3:0] co, input logic d,
                             input logic b, input logic r, input logic [31:0] p);
    ev_t e;
    e.cyc = c; e.coils = co; e.done = d; e.busy = b; e.ready = r; e.pos = p;
    return e;
  endfunction

  // Model a command accepted on edge acc; only the first `limit` steps are expected.
  task automatic push_cmd(input int acc, input int n, input int per, input bit half,
                          input bit dir, input int limit);
    int p = (per == 0) ? 1 : per;
    int d = half ? 1 : 2;
    if (n == 0) begin
      exp_q.push_back(mk(acc, tb_map[m_phase], 1'b1, 1'b0, 1'b1, m_pos));
      return;
    end
    for (int i = 1; i <= n && i <= limit; i++) begin
      m_phase = dir ? (m_phase - d + 8) % 8 : (m_phase + d) % 8;
      m_pos   = dir ? m_pos - 32'(d) : m_pos + 32'(d);
      exp_q.push_back(mk(acc + i * p, tb_map[m_phase], i == n, i != n, i == n, m_pos));
    end
  endtask

  task automatic wait_until(input int target);
    int guard = 0;
    while (cyc < target && guard < 2000) begin
      @(negedge CLK);
      guard++;
    end
  endtask

  // Issues one command at the next falling edge; returns the accept edge number.
  task automatic issue(input int n, input int per, input bit half, input bit dir,
                       input int limit, output int acc);
    @(negedge CLK);
    check("ready_before_issue", 64'(CMD_READY), 64'd1);
    CMD_STEPS = 16'(n); PERIOD = 16'(per); HALF = half; DIR = dir; CMD_VALID = 1'b1;
    acc = cyc + 1;
    push_cmd(acc, n, per, half, dir, limit);
    @(negedge CLK);
    CMD_VALID = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0; EN = 1'b0;
    #1;
    check("rst_coils", 64'({A, AN, B, BN}), 64'h0);
    check("rst_busy_done", 64'({BUSY, DONE}), 64'h0);
    check("rst_pos", 64'(POS), 64'h0);
    m_phase = 0; m_pos = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    EN = 1'b1;
    #1;
    check("ready_before_en_edge", 64'(CMD_READY), 64'h0);
    exp_q.push_back(mk(cyc + 1, 4'b1000, 1'b0, 1'b0, 1'b1, 32'h0));
    @(negedge CLK);
  endtask

  logic [3:0] mon_prev = 4'b0;
  logic [3:0] mon_cur;
  ev_t        mon_e;
  always @(negedge CLK) begin
    mon_cur = {A, AN, B, BN};
    if (!RST) begin
      mon_prev = 4'b0;
    end else begin
      if (mon_cur !== mon_prev || DONE === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got coils %b done %b at cycle %0d, expected no event",
                   mon_cur, DONE, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("ev_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("ev_coils", 64'(mon_cur), 64'(mon_e.coils));
          check("ev_done", 64'(DONE), 64'(mon_e.done));
          check("ev_busy", 64'(BUSY), 64'(mon_e.busy));
          check("ev_ready", 64'(CMD_READY), 64'(mon_e.ready));
          check("ev_pos", 64'(POS), 64'(mon_e.pos));
        end
      end
      mon_prev = mon_cur;
    end
  end

  initial begin
    int acc, acc2, k;

    // 1: full-step forward, P=4, 4 steps -> POS 8
    do_reset();
    issue(4, 4, 1'b0, 1'b0, 100, acc);
    wait_until(acc + 17);

    // 2: half-step reverse, P=1, 3 steps from phase 0 -> POS -3
    do_reset();
    issue(3, 1, 1'b1, 1'b1, 100, acc);
    wait_until(acc + 4);

    // 3: zero-step command -> DONE only, BUSY never high
    issue(0, 3, 1'b0, 1'b0, 100, acc);
    for (int i = 0; i < 4; i++) begin
      check("zero_cmd_busy", 64'(BUSY), 64'h0);
      @(negedge CLK);
    end

    // 4: abort after the 3rd full step, P=2, then re-enable
    do_reset();
    issue(10, 2, 1'b0, 1'b0, 3, acc);
    wait_until(acc + 6);
    EN = 1'b0;
    exp_q.push_back(mk(acc + 7, 4'b0000, 1'b0, 1'b0, 1'b0, 32'd6));
    repeat (3) @(negedge CLK);
    check("abort_busy", 64'(BUSY), 64'h0);
    EN = 1'b1;
    exp_q.push_back(mk(cyc + 1, 4'b0001, 1'b0, 1'b0, 1'b1, 32'd6));
    repeat (2) @(negedge CLK);

    // 5: back-to-back, second command held on CMD_VALID; inputs change mid-run
    @(negedge CLK);
    CMD_STEPS = 16'd2; PERIOD = 16'd3; HALF = 1'b1; DIR = 1'b0; CMD_VALID = 1'b1;
    acc = cyc + 1;
    push_cmd(acc, 2, 3, 1'b1, 1'b0, 100);
    @(negedge CLK);
    CMD_STEPS = 16'd2; PERIOD = 16'd2; HALF = 1'b0; DIR = 1'b1;
    acc2 = acc + 2 * 3 + 1;
    push_cmd(acc2, 2, 2, 1'b0, 1'b1, 100);
    wait_until(acc2);
    CMD_VALID = 1'b0;
    check("b2b_busy_after_accept", 64'(BUSY), 64'h1);
    wait_until(acc2 + 5);

    // 6: PERIOD=0 behaves as 1
    issue(2, 0, 1'b0, 1'b0, 100, acc);
    wait_until(acc + 3);

    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge CLK);
      k++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stepper_seq_ctrl.md
Name: stepper_seq_ctrl

Overview:
Parametrised stepper-motor phase sequencer. It is the successor to the fixed 2-bit counter/decoder/XOR-direction motor driver. Adds:
- programmable step rate
- full/half-step modes
- commanded step counts with a valid/ready handshake
- enable/abort
- a signed position counter

Drives the four coil lines A, AN, B, BN of one unipolar motor from the system clock.

Parameters:
DIV_W, 16, width of the step-period prescaler and of PERIOD
CNT_W, 16, width of the commanded step count
POS_W, 32, width of the signed position counter (half-step units)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous active-low reset
EN  in  1  driver enable; low de-energises coils and aborts any run
DIR  in  1  0 = forward (phase index +), 1 = reverse (phase index -)
HALF  in  1  1 = half-step mode, 0 = full-step mode
PERIOD  in  DIV_W  clock cycles per step; 0 is treated as 1
CMD_VALID  in  1  step command valid
CMD_STEPS  in  CNT_W  number of steps to execute
CMD_READY  out  1  high when a command can be accepted
BUSY  out  1  run in progress
DONE  out  1  one-cycle pulse when a command completes normally
POS  out  POS_W  signed position, two's complement, half-step units
A  out  1  coil A
AN  out  1  coil A-bar
B  out  1  coil B
BN  out  1  coil B-bar

Behaviour:
- Reset (RST=0, async): state IDLE, phase index 0, prescaler 0, remaining 0, POS 0. A, AN, B, BN, BUSY, DONE all 0. CMD_READY=0 until first edge after release with EN=1.
- Phase index 0..7 maps to coils {A,AN,B,BN}:
  - 0=1000, 1=1010, 2=0010, 3=0110
  - 4=0100, 5=0101, 6=0001, 7=1001
- Coil outputs are registered and equal the map of the current phase when EN=1 and the block has been out of reset for at least one edge. Otherwise they are 0000.
- CMD_READY = (state==IDLE) && EN. Accept = CMD_VALID && CMD_READY at a rising edge.
- DIR, HALF and PERIOD are latched at accept and ignored during the run. Step delta is ±1 (HALF=1) or ±2 (HALF=0), phase arithmetic mod 8.
  - Full-step from an even index gives wave drive; from an odd index it gives two-phase drive. No snapping.
- States:
  - IDLE: on accept with CMD_STEPS=0, DONE pulses on the next cycle, no step, stay IDLE. On accept with CMD_STEPS>0, load remaining and clear the prescaler, then go to RUN.
  - RUN: prescaler counts 0..P-1, where P = max(PERIOD,1). At count P-1 a step fires: phase += delta, POS += delta (wraps mod 2^POS_W), remaining -= 1, prescaler returns to 0. When remaining reaches 0 on a step, go to IDLE and pulse DONE in that same cycle.
- Latency:
  - If the accept edge is cycle 0, the first phase change is visible after edge P. The n-th step is visible after edge n·P.
  - CMD_READY returns high the cycle DONE is high, so back-to-back commands lose no cycles.
- BUSY = (state==RUN).
- EN falling in RUN: abort on the next edge. State goes to IDLE, remaining cleared, no DONE, coils 0000. Phase and POS are retained. Re-enable resumes from the retained phase.
- CMD_VALID while not ready: ignored; the upstream holds it.
- Reset asserted mid-run: immediate return to all reset values.

Decomposition:
- Shared package stepper_pkg holds:
  - phase-to-coil lookup constant (8 entries × 4 bits)
  - state enum (IDLE, RUN)
  - phase index width constant (3)
- One sub-module is natural: step_prescaler (DIV_W-bit counter with clear input, terminal-count tick output, PERIOD=0 treated as 1).

Test Plan:
1. Reset then EN=1, HALF=0, DIR=0, PERIOD=4, CMD_STEPS=4:
   - coils 1000→0010→0100→0001→1000 at edges 4, 8, 12, 16 after accept
   - DONE pulses at edge 16; POS=8
2. HALF=1, DIR=1, PERIOD=1, CMD_STEPS=3 from phase 0:
   - phases 7, 6, 5 on consecutive cycles, coils 1001, 0001, 0101
   - POS=-3 (all ones except LSB pattern 0xFFFFFFFD)
3. CMD_STEPS=0 accepted:
   - DONE pulses one cycle later
   - coils and POS unchanged; BUSY never high
4. PERIOD=2, CMD_STEPS=10, EN dropped after the 3rd step:
   - next edge gives coils 0000, BUSY=0, no DONE, POS=6 (full-step)
   - re-enable drives coils for phase 6 (0001)
5. Back-to-back: a second command held on CMD_VALID is accepted on the cycle the first command's DONE is high. Its first step follows P cycles later.
6. PERIOD=0, CMD_STEPS=2: steps fire on consecutive cycles, identical to PERIOD=1.
